// File: rtl/seq_multiplier_if.sv
// Handshake bundle between the execute stage and the iterative multiplier.
// Ports: flush/in_valid/op/A/B/out_ready go into the unit;
//        in_ready/out_valid/Y/busy come back from it.
interface seq_multiplier_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] Y;
  logic            busy;

  // Pipeline side drives operands and consumes results.
  modport master (
    output flush, in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, Y, busy
  );

  // Multiplier side.
  modport slave (
    input  flush, in_valid, op, A, B, out_ready,
    output in_ready, out_valid, Y, busy
  );
endinterface

// File: rtl/seq_multiplier.sv
// Half adder cell used as the LSB stage of the ripple adder.
// Latency: combinational.
// Backpressure: none.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// Full adder cell used for the upper stages of the ripple adder.
// Latency: combinational.
// Backpressure: none.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// Iterative shift-and-add multiplier for MUL/MULH/MULHSU/MULHU.
// Latency: XLEN+2 edges from accept to out_valid (load, XLEN adds, sign fix).
// Backpressure: holds result in DONE until out_ready; in_ready only in IDLE.
// Ports: clk, rst_n (async active-low), bus (slave modport: flush, in_valid/
//        in_ready, op, A, B, out_valid/out_ready, Y, busy).
module seq_multiplier #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_multiplier_if.slave bus
);
  localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_n;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mcand;
  logic [CW-1:0]     cnt;
  logic              neg;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   y_q;

  logic              accept;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN-1:0]   addend, sum;
  logic [XLEN-1:0]   carry;
  logic [2*XLEN-1:0] prod_fix;

  assign accept = (state == IDLE) && bus.in_valid && !bus.flush;

  // A is signed for MULH (01) and MULHSU (10); B only for MULH.
  assign a_neg = ((bus.op == 2'b01) || (bus.op == 2'b10)) && bus.A[XLEN-1];
  assign b_neg = (bus.op == 2'b01) && bus.B[XLEN-1];
  // Negating the most-negative value yields 2^(XLEN-1), still a valid magnitude.
  assign a_mag = a_neg ? -bus.A : bus.A;
  assign b_mag = b_neg ? -bus.B : bus.B;

  // Ripple adder: upper product half + (multiplier LSB ? multiplicand : 0).
  assign addend = product[0] ? mcand : '0;

  half_adder u_ha0 (
    .a (product[XLEN]),
    .b (addend[0]),
    .s (sum[0]),
    .c (carry[0])
  );

  for (genvar i = 1; i < XLEN; i++) begin : g_fa
    full_adder u_fa (
      .a    (product[XLEN+i]),
      .b    (addend[i]),
      .cin  (carry[i-1]),
      .s    (sum[i]),
      .cout (carry[i])
    );
  end

  assign prod_fix = neg ? -product : product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (accept) state_n = CALC;
      end
      CALC: if (cnt == CNT_LAST) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Abort wins over everything, including a DONE handshake.
    if (bus.flush) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= '0;
      mcand   <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      op_q    <= 2'b00;
      y_q     <= '0;
    end else if (!bus.flush) begin
      case (state)
        IDLE: if (accept) begin
          op_q    <= bus.op;
          mcand   <= a_mag;
          product <= {{XLEN{1'b0}}, b_mag};
          cnt     <= '0;
          neg     <= a_neg ^ b_neg;
        end
        CALC: begin
          // Carry-out becomes the new MSB as the whole product shifts right.
          product <= {carry[XLEN-1], sum, product[XLEN-1:1]};
          cnt     <= cnt + CW'(1);
        end
        FIX: begin
          product <= prod_fix;
          y_q     <= (op_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
        default: ;
      endcase
    end
  end

  assign bus.Y = y_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed RV32M cases, latency,
// backpressure, flush, asynchronous reset and a random scoreboard sweep.
module tb_seq_multiplier;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_multiplier_if #(.XLEN(XLEN)) mif ();

  seq_multiplier #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Present an op, wait (bounded) for in_ready, push the expectation on accept.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output bit ok);
    int k;
    k = 0;
    mif.op = op; mif.A = a; mif.B = b; mif.in_valid = 1'b1;
    while (!mif.in_ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    ok = mif.in_ready;
    if (ok) begin
      exp_q.push_back(ref_mul(op, a, b));
      @(posedge clk); #1;
    end
    mif.in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit got, output int edges);
    edges = 0;
    while (!mif.out_valid && edges < 200) begin
      @(posedge clk); #1; edges++;
    end
    got = mif.out_valid;
  endtask

  task automatic retire();
    mif.out_ready = 1'b1;
    @(posedge clk); #1;
    mif.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({mif.in_ready, mif.out_valid, mif.busy, mif.Y} !== {1'b1, 1'b0, 1'b0, 32'h0})
      $display("FAIL reset_state: got rdy/vld/busy/Y=%b/%b/%b/%h want 1/0/0/0", mif.in_ready, mif.out_valid, mif.busy, mif.Y);
    else n_pass++;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int n;
    bit rdy_seen;
    mif.op = 2'b00; mif.A = 32'd7; mif.B = 32'd6; mif.in_valid = 1'b1;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    n = 1;
    rdy_seen = 1'b0;
    while (!mif.out_valid && n < 200) begin
      if (mif.in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1; n++;
    end
    if (mif.in_ready) rdy_seen = 1'b1;
    n_checks++;
    if (n !== 34) $display("FAIL mul_latency: got %0d edges want 34", n); else n_pass++;
    n_checks++;
    if (rdy_seen !== 1'b0) $display("FAIL mul_in_ready_low: got in_ready high while busy want low"); else n_pass++;
    n_checks++;
    if (mif.Y !== 32'h0000_002A) $display("FAIL mul_7x6: got %h want 0000002a", mif.Y); else n_pass++;
    retire();
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [6] = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00};
    logic [31:0] t_a  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
    logic [31:0] t_b  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] t_y  [6] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'h80000000};
    bit ok, got;
    int e;
    logic [31:0] exp;
    for (int i = 0; i < 6; i++) begin
      send(t_op[i], t_a[i], t_b[i], ok);
      wait_out(got, e);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || !got)
        $display("FAIL directed_%0d_timeout: got no result want Y=%h", i, t_y[i]);
      else if (mif.Y !== t_y[i] || exp !== t_y[i])
        $display("FAIL directed_%0d: got %h (model %h) want %h", i, mif.Y, exp, t_y[i]);
      else n_pass++;
      retire();
    end
  endtask

  task automatic test_back_to_back();
    bit ok, got, stable;
    int e;
    logic [31:0] exp;
    send(2'b11, 32'hDEADBEEF, 32'h12345678, ok);
    wait_out(got, e);
    exp = exp_q.pop_front();
    stable = ok && got && (mif.Y === exp);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!mif.out_valid || mif.Y !== exp) stable = 1'b0;
    end
    n_checks++;
    if (!stable) $display("FAIL backpressure_hold: got vld=%b Y=%h want vld=1 Y=%h", mif.out_valid, mif.Y, exp); else n_pass++;
    retire();
    n_checks++;
    if ({mif.out_valid, mif.in_ready, mif.Y} !== {1'b0, 1'b1, exp})
      $display("FAIL backpressure_release: got vld/rdy/Y=%b/%b/%h want 0/1/%h", mif.out_valid, mif.in_ready, mif.Y, exp);
    else n_pass++;
    send(2'b10, 32'hFFFF_FFF9, 32'd1000, ok);
    wait_out(got, e);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || !got || mif.Y !== 32'hFFFF_FFFF)
      $display("FAIL back_to_back: got ok=%b vld=%b Y=%h want Y=ffffffff (model %h)", ok, got, mif.Y, exp);
    else n_pass++;
    retire();
  endtask

  task automatic test_flush();
    bit ok, got, pulse;
    int e;
    logic [31:0] exp;
    send(2'b00, 32'd1234, 32'd5678, ok);
    repeat (5) begin @(posedge clk); #1; end
    mif.flush = 1'b1;
    @(posedge clk); #1;
    mif.flush = 1'b0;
    if (ok) void'(exp_q.pop_back());
    n_checks++;
    if ({mif.busy, mif.in_ready, mif.out_valid} !== 3'b010)
      $display("FAIL flush_calc: got busy/rdy/vld=%b/%b/%b want 0/1/0", mif.busy, mif.in_ready, mif.out_valid);
    else n_pass++;
    pulse = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mif.out_valid) pulse = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (pulse) $display("FAIL flush_no_result: got out_valid pulse want none"); else n_pass++;
    send(2'b00, 32'd3, 32'd5, ok);
    wait_out(got, e);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || !got || mif.Y !== 32'd15)
      $display("FAIL flush_then_mul: got vld=%b Y=%h want 0000000f (model %h)", got, mif.Y, exp);
    else n_pass++;
    retire();
    mif.flush = 1'b1; mif.in_valid = 1'b1; mif.op = 2'b00; mif.A = 32'd9; mif.B = 32'd9;
    @(posedge clk); #1;
    mif.flush = 1'b0; mif.in_valid = 1'b0;
    n_checks++;
    if ({mif.busy, mif.in_ready} !== 2'b01)
      $display("FAIL flush_beats_valid: got busy/rdy=%b/%b want 0/1", mif.busy, mif.in_ready);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    bit ok;
    send(2'b11, 32'hCAFEF00D, 32'h0BADC0DE, ok);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mif.in_ready, mif.out_valid, mif.busy, mif.Y} !== {1'b1, 1'b0, 1'b0, 32'h0})
      $display("FAIL async_reset: got rdy/vld/busy/Y=%b/%b/%b/%h want 1/0/0/0", mif.in_ready, mif.out_valid, mif.busy, mif.Y);
    else n_pass++;
    exp_q.delete();
    #13 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit ok, got;
    int e, errs;
    logic [1:0]  op;
    logic [31:0] a, b, exp;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      op = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      send(op, a, b, ok);
      wait_out(got, e);
      if (!ok || !got) begin
        n_checks++;
        $display("FAIL random_timeout: op %0d got no result want one", i);
        break;
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (mif.Y !== exp) begin
        if (errs < 10) $display("FAIL random_op%0d: op=%b A=%h B=%h got %h want %h", i, op, a, b, mif.Y, exp);
        errs++;
      end else n_pass++;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      retire();
    end
  endtask

  initial begin
    mif.flush = 1'b0; mif.in_valid = 1'b0; mif.op = 2'b00;
    mif.A = '0; mif.B = '0; mif.out_ready = 1'b0;
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
